// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and lamp bit positions for the intersection controller
package traffic_pkg;

  typedef enum logic [3:0] {
    AR0    = 4'd0,
    AR1    = 4'd1,
    NS_L   = 4'd2,
    NS_LY  = 4'd3,
    NS_S   = 4'd4,
    NS_SY  = 4'd5,
    EW_L   = 4'd6,
    EW_LY  = 4'd7,
    EW_S   = 4'd8,
    EW_SY  = 4'd9,
    EMG_NS = 4'd10,
    EMG_EW = 4'd11,
    FLASH  = 4'd12
  } state_t;

  localparam int LAMP_RED = 3;
  localparam int LAMP_YEL = 2;
  localparam int LAMP_GL  = 1;
  localparam int LAMP_GS  = 0;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter with freeze and zero flag, used for phase and flash timing
module phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] i_rst_val,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_freeze,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Saturates at zero so a state held past its time cannot wrap the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= i_rst_val;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (!i_freeze && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/traffic_ctrl_adaptive.sv
// rtl/traffic_ctrl_adaptive.sv - adaptive 4-way controller with left skip, walk, preemption and night flash
module traffic_ctrl_adaptive
  import traffic_pkg::*;
#(
  parameter int T_LEFT     = 20,
  parameter int T_STRAIGHT = 40,
  parameter int T_YELLOW   = 10,
  parameter int T_ALLRED   = 4,
  parameter int T_WALK     = 15,
  parameter int T_FLASH    = 8,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flash_mode,
  input  logic       ns_left_req,
  input  logic       ew_left_req,
  input  logic       ped_req_ns,
  input  logic       ped_req_ew,
  input  logic       emg_req,
  input  logic       emg_axis,
  output logic [3:0] n_lamp,
  output logic [3:0] s_lamp,
  output logic [3:0] e_lamp,
  output logic [3:0] w_lamp,
  output logic       ped_walk_ns,
  output logic       ped_walk_ew,
  output logic       emg_ack,
  output logic [3:0] phase
);

  localparam logic [CNT_W-1:0] L_ALLRED  = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] L_LEFT    = CNT_W'(T_LEFT - 1);
  localparam logic [CNT_W-1:0] L_STRT    = CNT_W'(T_STRAIGHT - 1);
  localparam logic [CNT_W-1:0] L_YELLOW  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_FLASH   = CNT_W'(T_FLASH - 1);
  localparam logic [CNT_W-1:0] L_WALK_TH = CNT_W'(T_STRAIGHT - T_WALK);

  state_t           r_state, w_next, w_emg_st;
  logic [CNT_W-1:0] w_cnt, w_load_val;
  logic             w_zero, w_load, w_in_emg;
  logic             r_lns, r_lew, r_pns, r_pew, r_walk_ns, r_walk_ew;
  logic             r_emg_d, r_emg_pend, r_emg_ax, r_flash_on;
  logic             w_rise, w_pend, w_ax;
  logic             w_ent_nsl, w_ent_ewl, w_walk_ns_go, w_walk_ew_go;
  logic [3:0]       w_ns_lamp, w_ew_lamp;

  // A preemption is live only while emg_req stays high; dropping it early cancels it.
  assign w_rise   = emg_req & ~r_emg_d;
  assign w_pend   = emg_req & (r_emg_pend | w_rise);
  assign w_ax     = w_rise ? emg_axis : r_emg_ax;
  assign w_emg_st = w_ax ? EMG_EW : EMG_NS;
  assign w_in_emg = (r_state == EMG_NS) || (r_state == EMG_EW);

  always_comb begin
    w_next = r_state;
    case (r_state)
      AR0:    if (w_zero) w_next = w_pend ? w_emg_st : (r_lns ? NS_L : NS_S);
      AR1:    if (w_zero) w_next = w_pend ? w_emg_st : (r_lew ? EW_L : EW_S);
      NS_L:   if (w_pend) w_next = w_ax ? NS_LY : EMG_NS;
              else if (w_zero) w_next = NS_LY;
      NS_LY:  if (w_zero) w_next = w_pend ? (w_ax ? AR1 : EMG_NS) : NS_S;
      NS_S:   if (w_pend) w_next = w_ax ? NS_SY : EMG_NS;
              else if (w_zero) w_next = NS_SY;
      NS_SY:  if (w_zero) w_next = (w_pend && !w_ax) ? EMG_NS : AR1;
      EW_L:   if (w_pend) w_next = w_ax ? EMG_EW : EW_LY;
              else if (w_zero) w_next = EW_LY;
      EW_LY:  if (w_zero) w_next = w_pend ? (w_ax ? EMG_EW : AR0) : EW_S;
      EW_S:   if (w_pend) w_next = w_ax ? EMG_EW : EW_SY;
              else if (w_zero) w_next = EW_SY;
      EW_SY:  if (w_zero) w_next = (w_pend && w_ax) ? EMG_EW : AR0;
      EMG_NS: if (!emg_req) w_next = NS_SY;
      EMG_EW: if (!emg_req) w_next = EW_SY;
      FLASH:  if (w_pend) w_next = w_emg_st;
              else if (!flash_mode) w_next = AR0;
      default: w_next = AR0;
    endcase
    if (flash_mode && !w_pend && !w_in_emg && (r_state != FLASH)) begin
      w_next = FLASH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= AR0;
    else      r_state <= w_next;
  end

  always_comb begin
    w_load_val = '0;
    case (w_next)
      AR0, AR1:                   w_load_val = L_ALLRED;
      NS_L, EW_L:                 w_load_val = L_LEFT;
      NS_S, EW_S:                 w_load_val = L_STRT;
      NS_LY, NS_SY, EW_LY, EW_SY: w_load_val = L_YELLOW;
      FLASH:                      w_load_val = L_FLASH;
      default:                    w_load_val = '0;
    endcase
  end

  // FLASH reuses the phase timer as its half-period counter.
  assign w_load = (w_next != r_state) || ((r_state == FLASH) && w_zero);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_rst_val  (L_ALLRED),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_freeze   (w_in_emg),
    .o_cnt      (w_cnt),
    .o_zero     (w_zero)
  );

  assign w_ent_nsl    = (w_next == NS_L) && (r_state != NS_L);
  assign w_ent_ewl    = (w_next == EW_L) && (r_state != EW_L);
  assign w_walk_ns_go = (w_next == NS_S) && (r_state != NS_S) && r_pns;
  assign w_walk_ew_go = (w_next == EW_S) && (r_state != EW_S) && r_pew;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lns      <= 1'b1;
      r_lew      <= 1'b1;
      r_pns      <= 1'b0;
      r_pew      <= 1'b0;
      r_walk_ns  <= 1'b0;
      r_walk_ew  <= 1'b0;
      r_emg_d    <= 1'b0;
      r_emg_pend <= 1'b0;
      r_emg_ax   <= 1'b0;
      r_flash_on <= 1'b0;
    end else begin
      r_emg_d <= emg_req;
      if (!emg_req)    r_emg_pend <= 1'b0;
      else if (w_rise) r_emg_pend <= 1'b1;
      if (w_rise && !w_in_emg) r_emg_ax <= emg_axis;
      // Leaving night flash restores full left service on both axes.
      if ((r_state == FLASH) && (w_next == AR0)) begin
        r_lns <= 1'b1;
        r_lew <= 1'b1;
      end else begin
        r_lns <= ns_left_req | (r_lns & ~w_ent_nsl);
        r_lew <= ew_left_req | (r_lew & ~w_ent_ewl);
      end
      r_pns     <= ped_req_ns | (r_pns & ~w_walk_ns_go);
      r_pew     <= ped_req_ew | (r_pew & ~w_walk_ew_go);
      r_walk_ns <= w_walk_ns_go | (r_walk_ns & (w_next == NS_S));
      r_walk_ew <= w_walk_ew_go | (r_walk_ew & (w_next == EW_S));
      if ((w_next == FLASH) && (r_state != FLASH)) r_flash_on <= 1'b1;
      else if ((r_state == FLASH) && w_zero)       r_flash_on <= ~r_flash_on;
    end
  end

  always_comb begin
    w_ns_lamp = '0;
    w_ew_lamp = '0;
    w_ns_lamp[LAMP_RED] = 1'b1;
    w_ew_lamp[LAMP_RED] = 1'b1;
    case (r_state)
      NS_L:          begin w_ns_lamp = '0; w_ns_lamp[LAMP_GL] = 1'b1; end
      NS_S:          begin w_ns_lamp = '0; w_ns_lamp[LAMP_GS] = 1'b1; end
      NS_LY, NS_SY:  begin w_ns_lamp = '0; w_ns_lamp[LAMP_YEL] = 1'b1; end
      EW_L:          begin w_ew_lamp = '0; w_ew_lamp[LAMP_GL] = 1'b1; end
      EW_S:          begin w_ew_lamp = '0; w_ew_lamp[LAMP_GS] = 1'b1; end
      EW_LY, EW_SY:  begin w_ew_lamp = '0; w_ew_lamp[LAMP_YEL] = 1'b1; end
      EMG_NS: begin
        w_ns_lamp = '0;
        w_ns_lamp[LAMP_GL] = 1'b1;
        w_ns_lamp[LAMP_GS] = 1'b1;
      end
      EMG_EW: begin
        w_ew_lamp = '0;
        w_ew_lamp[LAMP_GL] = 1'b1;
        w_ew_lamp[LAMP_GS] = 1'b1;
      end
      FLASH: begin
        w_ns_lamp = '0;
        w_ew_lamp = '0;
        w_ns_lamp[LAMP_YEL] = r_flash_on;
        w_ew_lamp[LAMP_YEL] = r_flash_on;
      end
      default: ;
    endcase
  end

  assign n_lamp      = w_ns_lamp;
  assign s_lamp      = w_ns_lamp;
  assign e_lamp      = w_ew_lamp;
  assign w_lamp      = w_ew_lamp;
  assign ped_walk_ns = (r_state == NS_S) && r_walk_ns && (w_cnt >= L_WALK_TH);
  assign ped_walk_ew = (r_state == EW_S) && r_walk_ew && (w_cnt >= L_WALK_TH);
  assign emg_ack     = w_in_emg;
  assign phase       = r_state;

endmodule
